mips_cpu_mem_arbiter: RTL and testbench

- Shares one Avalon-MM memory port between the CPU's instruction-fetch and data-access paths.
- Sequences every CPU instruction as: fetch, settle, optional data access, one-cycle commit pulse on `cpu_step`.
- `cpu_step` drives the CPU's `clk_enable`, so the CPU only advances when fetch and data results are latched and stable.
- Sits between the CPU core and the bus-side memory.

---
 rtl/mips_cpu_pkg.sv | 20 ++
 rtl/mips_cpu_bus_watchdog.sv | 32 +++
 rtl/mips_cpu_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU memory arbiter.
package mips_cpu_pkg;

    // Arbiter sequencing states, one pass per CPU instruction
    typedef enum logic [2:0] {
        FETCH,
        SETTLE,
        DATA,
        COMMIT,
        HALT
    } arb_state_t;

    // Clears the byte-offset bits so every bus address is word aligned
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mips_cpu_bus_watchdog.sv
// Bus stall watchdog: counts consecutive waitrequest-high cycles of one
// transfer and flags a timeout on the TIMEOUT_CYCLES-th stall cycle.
module mips_cpu_bus_watchdog
    import mips_cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic i_stall,
    input  logic i_done,
    output logic o_timeout
);

    logic [TO_W-1:0] r_count;

    // The current stall cycle is the last one tolerated
    assign o_timeout = i_stall && (r_count == TO_W'(TIMEOUT_CYCLES - 1));

    // Stall counter, cleared whenever a transfer completes or times out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_done || o_timeout) begin
            r_count <= '0;
        end else if (i_stall) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one Avalon-MM port between CPU instruction fetch and data access.
// Each instruction runs FETCH -> SETTLE -> (DATA) -> COMMIT, and cpu_step
// pulses in COMMIT to clock-enable the CPU.
// Optional: define MIPS_CPU_MEM_ARB_TIMEOUT_EN to enable the stall watchdog.
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        cpu_step,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        bus_error
);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic        r_fetch_busy;     // fetch strobe already issued, cpu_active no longer sampled
    logic [31:0] r_instr;
    logic [31:0] r_data_rd;
    logic [31:0] r_data_addr;
    logic [31:0] r_data_wdata;
    logic [3:0]  r_data_be;
    logic        r_data_is_write;
    logic        r_bus_error;

    logic        w_fetch_strobe;
    logic        w_data_phase;
    logic        w_xfer;
    logic        w_done;
    logic        w_timeout;

    // A halted CPU is only noticed on the first FETCH cycle, before any strobe
    assign w_fetch_strobe = (r_state == FETCH) && (r_fetch_busy || cpu_active);
    assign w_data_phase   = (r_state == DATA);
    assign w_xfer         = w_fetch_strobe || w_data_phase;
    assign w_done         = w_xfer && !avm_waitrequest;

`ifdef MIPS_CPU_MEM_ARB_TIMEOUT_EN
    logic w_stall;
    assign w_stall = w_xfer && avm_waitrequest;

    mips_cpu_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_stall   (w_stall),
        .i_done    (w_done),
        .o_timeout (w_timeout)
    );
`else
    logic [TO_W-1:0] w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = TO_W'(TIMEOUT_CYCLES);
    assign w_timeout            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (!w_fetch_strobe || w_timeout) begin
                    w_state_next = HALT;
                end else if (w_done) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (data_write || data_read) begin
                    w_state_next = DATA;
                end else begin
                    w_state_next = COMMIT;
                end
            end
            DATA: begin
                if (w_timeout) begin
                    w_state_next = HALT;
                end else if (w_done) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT:  w_state_next = FETCH;
            HALT:    w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
    end

    // Bus and commit outputs; strobes are forced low while reset is held
    always_comb begin
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        cpu_step       = 1'b0;
        avm_address    = word_align(instr_address);
        avm_byteenable = 4'hF;
        if (r_state == DATA) begin
            avm_address    = r_data_addr;
            avm_byteenable = r_data_be;
        end
        if (!reset) begin
            case (r_state)
                FETCH:   avm_read = w_fetch_strobe;
                DATA: begin
                    avm_read  = !r_data_is_write;
                    avm_write = r_data_is_write;
                end
                COMMIT:  cpu_step = 1'b1;
                default: ;
            endcase
        end
    end

    assign avm_writedata  = r_data_wdata;
    assign instr_readdata = r_instr;
    assign data_readdata  = r_data_rd;
    assign bus_error      = r_bus_error;

    // Fetch handshake tracking and instruction latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_busy <= 1'b0;
            r_instr      <= '0;
        end else begin
            r_fetch_busy <= w_fetch_strobe && avm_waitrequest && !w_timeout;
            if (w_fetch_strobe && !avm_waitrequest) begin
                r_instr <= avm_readdata;
            end
        end
    end

    // Data request frozen in SETTLE so DATA holds a stable kind and address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_addr     <= '0;
            r_data_be       <= '0;
            r_data_wdata    <= '0;
            r_data_is_write <= 1'b0;
        end else if (r_state == SETTLE) begin
            r_data_addr     <= word_align(data_address);
            r_data_be       <= data_byteenable;
            r_data_wdata    <= data_writedata;
            r_data_is_write <= data_write;
        end
    end

    // Load data latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_rd <= '0;
        end else if (w_data_phase && !r_data_is_write && !avm_waitrequest) begin
            r_data_rd <= avm_readdata;
        end
    end

    // Sticky error: read/write conflict, or watchdog expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_error <= 1'b0;
        end else if (((r_state == SETTLE) && data_read && data_write) || w_timeout) begin
            r_bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Bench for mips_cpu_mem_arbiter: each instruction is expanded into its
// expected cycle-by-cycle bus schedule, which is replayed against the DUT.
module tb_mips_cpu_mem_arbiter;

    typedef struct {
        logic        rst;
        logic        act;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        drd;
        logic        dwr;
        logic [3:0]  dbe;
        logic        wreq;
        logic [31:0] rdata;
        int          cyc;
        logic        chk;
        logic        e_rd;
        logic        e_wr;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        chk_wd;
        logic [31:0] e_wd;
        logic        e_step;
        logic [31:0] e_ir;
        logic [31:0] e_dr;
        logic        e_berr;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        cpu_active;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        cpu_step;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        bus_error;

    mips_cpu_mem_arbiter #(
        .TIMEOUT_CYCLES (8),
        .TO_W           (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_active      (cpu_active),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .cpu_step        (cpu_step),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .bus_error       (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the CPU should currently see latched
    rec_t        q[$];
    rec_t        cur;
    logic        cur_valid;
    logic [31:0] m_ir;
    logic [31:0] m_dr;
    logic        m_berr;
    int          m_cyc;

    int          n_checks;
    int          n_errors;

    // Observations used to pin the model with hand-computed literals
    int          step_cyc[3];
    logic [31:0] step_dr[3];
    int          n_steps;
    logic        st_seen;
    logic [31:0] st_addr;
    logic [3:0]  st_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic rec_t base(input int kind, input logic [31:0] pc, input logic [31:0] da,
                                  input logic [31:0] dval, input logic [3:0] be);
        rec_t r;
        r.rst = 1'b0;   r.act = 1'b1;   r.ia = pc;      r.da = da;
        r.dwd = dval;   r.drd = (kind == 1) || (kind == 3);
        r.dwr = (kind == 2) || (kind == 3);
        r.dbe = be;     r.wreq = 1'b0;  r.rdata = 32'h0; r.cyc = 0;
        r.chk = 1'b1;   r.e_rd = 1'b0;  r.e_wr = 1'b0;
        r.chk_addr = 1'b0; r.e_addr = 32'h0; r.e_be = 4'h0;
        r.chk_wd = 1'b0; r.e_wd = 32'h0; r.e_step = 1'b0;
        r.e_ir = m_ir;  r.e_dr = m_dr;  r.e_berr = m_berr;
        return r;
    endfunction

    task automatic push(input rec_t r);
        rec_t t;
        t = r;
        if (!t.rst) begin
            m_cyc++;
            t.cyc = m_cyc;
        end
        q.push_back(t);
    endtask

    // Two reset cycles: the first applies reset, the second checks the cleared state
    task automatic add_reset();
        rec_t r;
        r = base(0, 32'h0, 32'h0, 32'h0, 4'h0);
        r.rst = 1'b1;
        r.wreq = 1'b1;
        r.chk = 1'b0;
        push(r);
        m_ir = 32'h0;
        m_dr = 32'h0;
        m_berr = 1'b0;
        m_cyc = 0;
        r = base(0, 32'h0, 32'h0, 32'h0, 4'h0);
        r.rst = 1'b1;
        r.wreq = 1'b1;
        push(r);
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 read+write conflict. abort>0 stops after that
    // many stalled data cycles without committing.
    task automatic add_instr(input int kind, input logic [31:0] pc, input logic [31:0] iword,
                             input int fw, input logic [31:0] da, input int dw,
                             input logic [31:0] dval, input logic [3:0] be, input int abort);
        rec_t r;
        for (int k = 0; k <= fw; k++) begin
            r = base(kind, pc, da, dval, be);
            r.e_rd = 1'b1;
            r.chk_addr = 1'b1;
            r.e_addr = {pc[31:2], 2'b00};
            r.e_be = 4'hF;
            r.wreq = (k < fw);
            r.rdata = (k < fw) ? (32'hBAD0_0000 | k) : iword;
            push(r);
        end
        m_ir = iword;
        push(base(kind, pc, da, dval, be));
        if (kind == 3) m_berr = 1'b1;
        if (kind != 0) begin
            for (int k = 0; k <= ((abort > 0) ? abort - 1 : dw); k++) begin
                r = base(kind, pc, da, dval, be);
                if (k > 0) r.da = da ^ 32'h0000_F000;
                r.e_rd = (kind == 1);
                r.e_wr = (kind >= 2);
                r.chk_addr = 1'b1;
                r.e_addr = {da[31:2], 2'b00};
                r.e_be = be;
                r.chk_wd = (kind >= 2);
                r.e_wd = dval;
                r.wreq = (abort > 0) || (k < dw);
                r.rdata = r.wreq ? (32'hBAD1_0000 | k) : ((kind == 1) ? dval : 32'h5555_AAAA);
                push(r);
            end
            if (abort > 0) return;
            if (kind == 1) m_dr = dval;
        end
        r = base(kind, pc, da, dval, be);
        r.e_step = 1'b1;
        push(r);
    endtask

    // Halted CPU: no bus activity even if cpu_active comes back
    task automatic add_halt(input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r = base(0, 32'hBFC0_0100, 32'h0, 32'h0, 4'hF);
            r.act = (k >= n / 2);
            r.rdata = 32'h7777_0000 | k;
            push(r);
        end
    endtask

    task automatic add_timeout_fetch(input logic [31:0] pc);
        rec_t r;
        for (int k = 0; k < 8; k++) begin
            r = base(0, pc, 32'h0, 32'h0, 4'hF);
            r.e_rd = 1'b1;
            r.chk_addr = 1'b1;
            r.e_addr = pc;
            r.e_be = 4'hF;
            r.wreq = 1'b1;
            push(r);
        end
        m_berr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r = base(0, pc, 32'h0, 32'h0, 4'hF);
            r.wreq = 1'b1;
            push(r);
        end
    endtask

    // Single compare process against the expected schedule
    always @(negedge clk) begin
        if (cur_valid && cur.chk) begin
            check("avm_read", {31'h0, avm_read}, {31'h0, cur.e_rd});
            check("avm_write", {31'h0, avm_write}, {31'h0, cur.e_wr});
            check("cpu_step", {31'h0, cpu_step}, {31'h0, cur.e_step});
            check("instr_readdata", instr_readdata, cur.e_ir);
            check("data_readdata", data_readdata, cur.e_dr);
            check("bus_error", {31'h0, bus_error}, {31'h0, cur.e_berr});
            if (cur.chk_addr) begin
                check("avm_address", avm_address, cur.e_addr);
                check("avm_byteenable", {28'h0, avm_byteenable}, {28'h0, cur.e_be});
            end
            if (cur.chk_wd) check("avm_writedata", avm_writedata, cur.e_wd);
            if (!cur.rst && cpu_step === 1'b1 && n_steps < 3) begin
                step_cyc[n_steps] = cur.cyc;
                step_dr[n_steps] = data_readdata;
                n_steps++;
            end
            if (!cur.rst && avm_write === 1'b1 && !st_seen) begin
                st_seen = 1'b1;
                st_addr = avm_address;
                st_be = avm_byteenable;
            end
        end
    end

    initial begin
        reset = 1'b1;
        cpu_active = 1'b1;
        instr_address = 32'h0;
        data_address = 32'h0;
        data_read = 1'b0;
        data_write = 1'b0;
        data_writedata = 32'h0;
        data_byteenable = 4'h0;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h0;
        cur_valid = 1'b0;
        m_ir = 32'h0;
        m_dr = 32'h0;
        m_berr = 1'b0;
        m_cyc = 0;
        n_checks = 0;
        n_errors = 0;
        n_steps = 0;
        st_seen = 1'b0;
        st_addr = 32'h0;
        st_be = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step_cyc[i] = 0;
            step_dr[i] = 32'h0;
        end

        add_reset();
        add_instr(0, 32'hBFC0_0000, 32'h0109_5020, 0, 32'h0, 0, 32'h0, 4'hF, 0);
        add_instr(1, 32'hBFC0_0004, 32'h8C48_0006, 1, 32'h0000_2006, 2, 32'hDEAD_BEEF, 4'hF, 0);
        add_instr(2, 32'hBFC0_0008, 32'hAC49_1003, 0, 32'h0000_1003, 1, 32'h1234_5678, 4'b0011, 0);
        add_instr(0, 32'hBFC0_000C, 32'h014B_6020, 3, 32'h0, 0, 32'h0, 4'hF, 0);
`ifndef MIPS_CPU_MEM_ARB_TIMEOUT_EN
        add_instr(0, 32'hBFC0_0010, 32'h016C_6820, 20, 32'h0, 0, 32'h0, 4'hF, 0);
`endif
        add_instr(3, 32'hBFC0_0014, 32'hDEAD_0001, 0, 32'h0000_3002, 0, 32'hCAFE_F00D, 4'hF, 0);
        add_instr(1, 32'hBFC0_0018, 32'h8C48_4000, 0, 32'h0000_4000, 0, 32'h0, 4'hF, 2);
        add_reset();
        add_instr(0, 32'hBFC0_0000, 32'h0109_5020, 0, 32'h0, 0, 32'h0, 4'hF, 0);
        add_halt(100);
`ifdef MIPS_CPU_MEM_ARB_TIMEOUT_EN
        add_reset();
        add_timeout_fetch(32'hBFC0_0000);
`endif

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            reset = q[i].rst;
            cpu_active = q[i].act;
            instr_address = q[i].ia;
            data_address = q[i].da;
            data_read = q[i].drd;
            data_write = q[i].dwr;
            data_writedata = q[i].dwd;
            data_byteenable = q[i].dbe;
            avm_waitrequest = q[i].wreq;
            avm_readdata = q[i].rdata;
            cur = q[i];
            cur_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;

        // ALU: 3 cycles; load with 1+2 stalls: 7; store with 1 stall: 5
        check("pin_step_alu", step_cyc[0], 3);
        check("pin_step_load", step_cyc[1], 10);
        check("pin_step_store", step_cyc[2], 15);
        check("pin_load_data", step_dr[1], 32'hDEAD_BEEF);
        check("pin_store_addr", st_addr, 32'h0000_1000);
        check("pin_store_be", {28'h0, st_be}, 32'h0000_0003);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
